edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Round-robin arbiter sitting between a bank of per-button sticky rising-edge detectors and the arpeggiator note sequencer. Each cycle in idle it scans the detectors' latched edge flags and grants one channel. It issues a one-cycle clear pulse back to that detector, then presents the channel index downstream over a valid/ready handshake. A programmable lockout after each accepted event provides simple debounce and rate limiting.

## Interface
- N_CH, 4: number of detector channels; 2..16; need not be a power of two.
- CODE_W, 2: width of ev_code; 2^CODE_W >= N_CH.
- LOCKOUT, 16: idle cycles enforced after each accepted event; 0 disables.
- LOCK_W, 8: lockout counter width; LOCKOUT < 2^LOCK_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- flags  in  N_CH  sticky edge flags, one per detector; stays high until that detector is cleared.
- clr  out  N_CH  registered clear to detectors; one-hot pulse on grant, all-ones during reset.
- ev_valid  out  1  event available.
- ev_ready  in  1  sequencer accepts event when high with ev_valid.
- ev_code  out  CODE_W  granted channel index; stable while ev_valid high.
- ev_count  out  8  accepted-event counter; wraps 255 -> 0.
- busy  out  1  high whenever state != IDLE.

## Operation
- Reset, while reset is sampled high:
  - State IDLE; rr_ptr, lockout counter, ev_code and ev_count are 0; ev_valid and busy are 0.
  - clr is all-ones, flushing every detector.
- States IDLE, CLEAR, PRESENT, LOCK.
- IDLE:
  - If any flags bit is high, select the first set index k searching rr_ptr, rr_ptr+1, …, wrapping at N_CH-1 -> 0.
  - Register ev_code=k and clr=one-hot(k), then go to CLEAR.
  - If no flag is set, remain in IDLE with clr=0.
- CLEAR:
  - clr[k] is high for exactly this one cycle.
  - Register ev_valid=1 and clr=0, then go to PRESENT.
- PRESENT:
  - Hold ev_valid=1 and ev_code=k until ev_valid&ev_ready.
  - On acceptance: ev_valid->0, ev_count+1 (mod 256), rr_ptr->(k+1) mod N_CH.
  - On acceptance, if LOCKOUT>0: load counter=LOCKOUT and go to LOCK; otherwise go to IDLE.
- LOCK:
  - Decrement the counter each cycle; go to IDLE on the cycle it reaches 0.
  - flags are ignored; no grants in this state.
- Flags are never lost; they are sticky upstream. A flag that re-asserts after its clear, including during PRESENT or LOCK, is served on a later scan.
- ev_ready while ev_valid is low has no effect.
- flags bits at or above N_CH do not exist; no out-of-range codes are ever produced.
- Reset in any state returns to IDLE the next cycle:
  - Any pending ev_valid is dropped.
  - ev_count is not incremented even if ev_ready is high in the reset cycle.

## Timing
- Grant latency: flag first sampled high in IDLE at edge t -> clr[k] high during cycle t+1 -> ev_valid high from cycle t+2.
- Acceptance sampled at edge p:
  - ev_valid low from cycle p+1.
  - With LOCKOUT=L>0: state LOCK for cycles p+1..p+L, IDLE at p+L+1, earliest next clr at p+L+2.
  - With LOCKOUT=0: IDLE at p+1, earliest next clr at p+2.
- Minimum spacing between consecutive clr pulses: 3+L cycles.
- Registered outputs only; no combinational path from any input to any output.
- Reset release: clr all-ones is last seen in the cycle after the final reset-high edge; clr=0 thereafter until the first grant.

## Test plan
- Reset sequence:
  - Stimulus: reset high 2 cycles.
  - Required: clr=4'b1111, ev_valid=0, ev_count=0, busy=0.
  - Required: one cycle after release, clr=0.
- Single event (N_CH=4, LOCKOUT=0):
  - Stimulus: flags=4'b0100 raised at t, ev_ready tied high.
  - Required: clr=4'b0100 at t+1, ev_valid=1 with ev_code=2 at t+2, ev_count=1 at t+3.
- Round robin:
  - Stimulus: flags=4'b1111, each bit dropped one cycle after its clr.
  - Required: grant order 0,1,2,3.
  - Follow-on stimulus: re-raise bits 0 and 3.
  - Required: next grant is 0; rr_ptr wrapped from 3 to 0.
- Backpressure:
  - Stimulus: ev_ready low for 10 cycles after ev_valid rises.
  - Required: ev_valid and ev_code stay stable; ev_count unchanged; exactly one clr pulse.
  - Required: acceptance on the 11th cycle.
- Lockout (LOCKOUT=16):
  - Stimulus: two flags pending.
  - Required: second clr occurs exactly 18 cycles after the first acceptance edge; busy stays high throughout the gap.
- Reset mid-PRESENT:
  - Stimulus: reset asserted while ev_valid=1 and ev_ready=1.
  - Required: ev_valid=0 next cycle, ev_count stays 0, clr=all-ones.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// ============================================================================
// Module      : edge_event_arbiter
// Description : Round-robin arbiter between sticky edge detectors and the
//               arpeggiator sequencer, with clear pulse and post-event lockout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_event_arbiter #(
    parameter int N_CH    = 4,
    parameter int CODE_W  = 2,
    parameter int LOCKOUT = 16,
    parameter int LOCK_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   flags,
    output logic [N_CH-1:0]   clr,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [CODE_W-1:0] ev_code,
    output logic [7:0]        ev_count,
    output logic              busy
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CLEAR   = 2'd1;
    localparam logic [1:0] c_PRESENT = 2'd2;
    localparam logic [1:0] c_LOCK    = 2'd3;

    localparam logic [CODE_W:0]   c_N_CH   = (CODE_W+1)'(N_CH);
    localparam logic [CODE_W-1:0] c_LAST   = CODE_W'(N_CH - 1);
    localparam logic [LOCK_W-1:0] c_LOCK_N = LOCK_W'(LOCKOUT);

    logic [1:0]        state_q,  state_d;
    logic [CODE_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [LOCK_W-1:0] lock_q,   lock_d;
    logic [CODE_W-1:0] code_q,   code_d;
    logic [7:0]        count_q,  count_d;
    logic              valid_q,  valid_d;
    logic [N_CH-1:0]   clr_q,    clr_d;
    logic              busy_q,   busy_d;

    logic              w_hit;
    logic [CODE_W-1:0] w_sel;

    // Scan starting at rr_ptr; the sum never exceeds 2*N_CH-2, so one
    // conditional subtraction wraps it back into range.
    always_comb begin
        logic [CODE_W:0] idx;
        w_hit = 1'b0;
        w_sel = '0;
        idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = {1'b0, rr_ptr_q} + (CODE_W+1)'(i);
            if (idx >= c_N_CH) begin
                idx = idx - c_N_CH;
            end
            if (!w_hit && flags[idx[CODE_W-1:0]]) begin
                w_hit = 1'b1;
                w_sel = idx[CODE_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        lock_d   = lock_q;
        code_d   = code_q;
        count_d  = count_q;
        valid_d  = valid_q;
        clr_d    = '0;
        case (state_q)
            c_IDLE: begin
                if (w_hit) begin
                    code_d  = w_sel;
                    clr_d   = N_CH'(1) << w_sel;
                    state_d = c_CLEAR;
                end
            end
            c_CLEAR: begin
                valid_d = 1'b1;
                state_d = c_PRESENT;
            end
            c_PRESENT: begin
                if (valid_q && ev_ready) begin
                    valid_d  = 1'b0;
                    count_d  = count_q + 8'd1;
                    rr_ptr_d = (code_q == c_LAST) ? '0 : code_q + CODE_W'(1);
                    if (LOCKOUT > 0) begin
                        lock_d  = c_LOCK_N;
                        state_d = c_LOCK;
                    end else begin
                        state_d = c_IDLE;
                    end
                end
            end
            c_LOCK: begin
                lock_d = lock_q - LOCK_W'(1);
                if (lock_q <= LOCK_W'(1)) begin
                    lock_d  = '0;
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
        busy_d = (state_d != c_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= c_IDLE;
            rr_ptr_q <= '0;
            lock_q   <= '0;
            code_q   <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            clr_q    <= '1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            lock_q   <= lock_d;
            code_q   <= code_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            clr_q    <= clr_d;
            busy_q   <= busy_d;
        end
    end

    assign clr      = clr_q;
    assign ev_valid = valid_q;
    assign ev_code  = code_q;
    assign ev_count = count_q;
    assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
// ============================================================================
// Module      : tb_edge_event_arbiter
// Description : Directed self-checking bench; instance A has no lockout,
//               instance B uses a 16-cycle lockout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] flags_a, flags_b, clr_a, clr_b;
    logic       valid_a, valid_b, ready_a, ready_b, busy_a, busy_b;
    logic [1:0] code_a, code_b;
    logic [7:0] count_a, count_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    edge_event_arbiter #(.N_CH(4), .CODE_W(2), .LOCKOUT(0), .LOCK_W(8)) u_dut_a (
        .clk(clk), .reset(rst), .flags(flags_a), .clr(clr_a),
        .ev_valid(valid_a), .ev_ready(ready_a), .ev_code(code_a),
        .ev_count(count_a), .busy(busy_a)
    );

    edge_event_arbiter #(.N_CH(4), .CODE_W(2), .LOCKOUT(16), .LOCK_W(8)) u_dut_b (
        .clk(clk), .reset(rst), .flags(flags_b), .clr(clr_b),
        .ev_valid(valid_b), .ev_ready(ready_b), .ev_code(code_b),
        .ev_count(count_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a clear pulse, returns its index and drops that sticky flag.
    task automatic wait_grant(input bit sel_b, output int idx);
        idx = -1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (sel_b ? (clr_b != 4'd0) : (clr_a != 4'd0)) begin
                for (int j = 0; j < 4; j++) begin
                    if (sel_b ? clr_b[j] : clr_a[j]) idx = j;
                end
                if (sel_b) flags_b &= ~clr_b;
                else       flags_a &= ~clr_a;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int g;
        int pulses;
        int ticks;
        bit stable;
        bit busy_ok;

        rst = 1'b1; flags_a = '0; flags_b = '0; ready_a = 1'b0; ready_b = 1'b0;
        tick(); tick();
        chk("rst_clr",   clr_a,   4'b1111);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_count", count_a, 8'd0);
        chk("rst_busy",  busy_a,  1'b0);
        chk("rst_clr_b", clr_b,   4'b1111);
        rst = 1'b0;
        tick();
        chk("rel_clr",   clr_a,   4'b0000);

        // Single event, ready tied high
        flags_a = 4'b0100; ready_a = 1'b1;
        tick();
        chk("single_clr", clr_a, 4'b0100);
        flags_a = 4'b0000;
        tick();
        chk("single_valid", valid_a, 1'b1);
        chk("single_code",  code_a,  2'd2);
        chk("single_clr0",  clr_a,   4'b0000);
        tick();
        chk("single_done",  valid_a, 1'b0);
        chk("single_count", count_a, 8'd1);

        // Round robin from a fresh pointer
        rst = 1'b1; tick(); rst = 1'b0; tick();
        flags_a = 4'b1111; ready_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(1'b0, g);
            chk("rr_order", g, k);
        end
        flags_a |= 4'b1001;
        wait_grant(1'b0, g);
        chk("rr_wrap", g, 0);
        wait_grant(1'b0, g);
        chk("rr_next", g, 3);
        tick();
        chk("rr_code", code_a, 2'd3);
        tick();
        chk("rr_count", count_a, 8'd6);

        // Backpressure: ready low for 10 cycles after valid rises
        ready_a = 1'b0; flags_a = 4'b0010; pulses = 0;
        wait_grant(1'b0, g);
        chk("bp_grant", g, 1);
        if (g >= 0) pulses++;
        tick();
        chk("bp_valid", valid_a, 1'b1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!valid_a || code_a != 2'd1 || count_a != 8'd6) stable = 1'b0;
            if (clr_a != 4'd0) pulses++;
            tick();
        end
        if (!valid_a || code_a != 2'd1 || count_a != 8'd6) stable = 1'b0;
        if (clr_a != 4'd0) pulses++;
        ready_a = 1'b1;
        tick();
        chk("bp_stable", stable, 1'b1);
        chk("bp_pulses", pulses, 1);
        chk("bp_accept", valid_a, 1'b0);
        chk("bp_count",  count_a, 8'd7);

        // Lockout of 16 cycles with two pending flags
        flags_b = 4'b0011; ready_b = 1'b1;
        wait_grant(1'b1, g);
        chk("lk_first", g, 0);
        tick();
        chk("lk_valid", valid_b, 1'b1);
        ticks = 0; busy_ok = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            ticks++;
            if (ticks <= 16 && !busy_b) busy_ok = 1'b0;
            if (clr_b != 4'd0) break;
        end
        chk("lk_gap",    ticks,   18);
        chk("lk_busy",   busy_ok, 1'b1);
        chk("lk_second", clr_b,   4'b0010);
        chk("lk_count",  count_b, 8'd1);
        flags_b &= ~clr_b;

        // Reset while an event is being accepted
        rst = 1'b1; tick(); rst = 1'b0;
        flags_a = 4'b0001; ready_a = 1'b0;
        wait_grant(1'b0, g);
        chk("mr_grant", g, 0);
        tick();
        chk("mr_valid", valid_a, 1'b1);
        ready_a = 1'b1; rst = 1'b1;
        tick();
        chk("mr_drop",  valid_a, 1'b0);
        chk("mr_count", count_a, 8'd0);
        chk("mr_clr",   clr_a,   4'b1111);
        chk("mr_busy",  busy_a,  1'b0);
        rst = 1'b0; ready_a = 1'b0;
        tick();
        chk("mr_rel_clr",   clr_a,   4'b0000);
        chk("mr_rel_count", count_a, 8'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
